gimli_hash_sequencer: RTL and testbench

Sequencer that turns a message word stream into a Gimli-Hash digest by driving the Gimli round core's command port (oper/din/din_size). It issues state zeroing, full-block absorbs, the padded final absorb (adding an empty padded block when the message length is a multiple of 16 bytes), and the squeeze-and-permute commands. It forwards the squeezed words to the digest output. It sits between the message source and one `gimli_rounds_simple` instance and owns that instance's command channel for the whole hash.

---
 rtl/gimli_hash_sequencer.sv | 168 ++++++++++++++++
 tb/tb_gimli_hash_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gimli_hash_sequencer.sv
// Gimli-Hash command sequencer: zero, absorb, pad, squeeze on a gimli_rounds_simple command port.
// Define GIMLI_HASH_XOF_EN to add the xof_blocks port (run-time squeeze word count).
module gimli_hash_sequencer #(
  parameter int DIGEST_BLOCKS = 2
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic [127:0] msg_din,
  input  logic [4:0]   msg_size,
  input  logic         msg_last,
  input  logic         msg_valid,
  output logic         msg_ready,
  output logic [127:0] hash_dout,
  output logic         hash_valid,
  input  logic         hash_ready,
  output logic         hash_last,
  output logic         busy,
  output logic [2:0]   core_oper,
  output logic [127:0] core_din,
  output logic [4:0]   core_din_size,
  output logic         core_din_valid,
  input  logic         core_din_ready,
  input  logic [127:0] core_dout,
  input  logic         core_dout_valid,
  output logic         core_dout_ready
`ifdef GIMLI_HASH_XOF_EN
  ,
  input  logic [7:0]   xof_blocks
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_ABSORB  = 3'd2;
  localparam logic [2:0] S_PAD     = 3'd3;
  localparam logic [2:0] S_SQUEEZE = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;

  localparam logic [2:0] OP_ABSORB  = 3'b000;
  localparam logic [2:0] OP_SQUEEZE = 3'b011;
  localparam logic [2:0] OP_INIT    = 3'b111;

  localparam logic [7:0] N_FIXED = 8'(DIGEST_BLOCKS);

  logic [2:0] state_q, state_d;
  logic [7:0] sq_cnt_q, sq_cnt_d;
  logic [7:0] out_cnt_q, out_cnt_d;
  logic [7:0] n_last;
  logic [4:0] eff_size;
  logic       cmd_hs;
  logic       out_hs;

`ifdef GIMLI_HASH_XOF_EN
  logic [7:0] n_q, n_d;

  // Word count is latched when a hash starts so later xof_blocks changes are ignored.
  always_comb begin
    n_d = n_q;
    if (state_q == S_IDLE && msg_valid) begin
      n_d = (xof_blocks == 8'd0) ? 8'd1 : xof_blocks;
    end
  end

  assign n_last = n_q - 8'd1;
`else
  assign n_last = N_FIXED - 8'd1;
`endif

  assign eff_size = (msg_size > 5'd16) ? 5'd16 : msg_size;

  // Digest path is a straight wire; the core's own handshake provides backpressure.
  assign hash_dout       = core_dout;
  assign hash_valid      = core_dout_valid;
  assign core_dout_ready = hash_ready;
  assign hash_last       = (out_cnt_q == n_last) & hash_valid;
  assign busy            = (state_q != S_IDLE);

  always_comb begin
    msg_ready      = 1'b0;
    core_din_valid = 1'b0;
    core_oper      = OP_INIT;
    core_din       = '0;
    core_din_size  = '0;
    case (state_q)
      S_INIT: begin
        core_din_valid = 1'b1;
      end
      S_ABSORB: begin
        core_oper      = OP_ABSORB;
        core_din       = msg_din;
        core_din_size  = msg_last ? eff_size : 5'd16;
        core_din_valid = msg_valid;
        msg_ready      = core_din_ready;
      end
      S_PAD: begin
        core_oper      = OP_ABSORB;
        core_din_valid = 1'b1;
      end
      S_SQUEEZE: begin
        core_oper      = OP_SQUEEZE;
        core_din_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign cmd_hs = core_din_valid & core_din_ready;
  assign out_hs = core_dout_valid & hash_ready;

  always_comb begin
    state_d   = state_q;
    sq_cnt_d  = sq_cnt_q;
    out_cnt_d = out_hs ? out_cnt_q + 8'd1 : out_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (msg_valid) state_d = S_INIT;
      end
      S_INIT: begin
        if (cmd_hs) state_d = S_ABSORB;
      end
      S_ABSORB: begin
        // A full final block still needs an empty padded block after it.
        if (cmd_hs && msg_last) begin
          state_d = (eff_size == 5'd16) ? S_PAD : S_SQUEEZE;
        end
      end
      S_PAD: begin
        if (cmd_hs) state_d = S_SQUEEZE;
      end
      S_SQUEEZE: begin
        if (cmd_hs) begin
          sq_cnt_d = sq_cnt_q + 8'd1;
          if (sq_cnt_q == n_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_hs && out_cnt_q == n_last) begin
          state_d   = S_IDLE;
          sq_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= S_IDLE;
      sq_cnt_q  <= '0;
      out_cnt_q <= '0;
`ifdef GIMLI_HASH_XOF_EN
      n_q       <= N_FIXED;
`endif
    end else begin
      state_q   <= state_d;
      sq_cnt_q  <= sq_cnt_d;
      out_cnt_q <= out_cnt_d;
`ifdef GIMLI_HASH_XOF_EN
      n_q       <= n_d;
`endif
    end
  end

endmodule

// File: tb/tb_gimli_hash_sequencer.sv
// Bench for gimli_hash_sequencer: stand-in round core with a toy permutation, byte-level reference, scoreboard.
module tb_gimli_hash_sequencer;

  logic         clk;
  logic         arstn;
  logic [127:0] msg_din;
  logic [4:0]   msg_size;
  logic         msg_last;
  logic         msg_valid;
  logic         msg_ready;
  logic [127:0] hash_dout;
  logic         hash_valid;
  logic         hash_ready;
  logic         hash_last;
  logic         busy;
  logic [2:0]   core_oper;
  logic [127:0] core_din;
  logic [4:0]   core_din_size;
  logic         core_din_valid;
  logic         core_din_ready;
  logic [127:0] core_dout;
  logic         core_dout_valid;
  logic         core_dout_ready;
`ifdef GIMLI_HASH_XOF_EN
  logic [7:0]   xof_blocks;
`endif

  gimli_hash_sequencer #(.DIGEST_BLOCKS(2)) dut (
    .clk(clk), .arstn(arstn),
    .msg_din(msg_din), .msg_size(msg_size), .msg_last(msg_last),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .hash_dout(hash_dout), .hash_valid(hash_valid), .hash_ready(hash_ready),
    .hash_last(hash_last), .busy(busy),
    .core_oper(core_oper), .core_din(core_din), .core_din_size(core_din_size),
    .core_din_valid(core_din_valid), .core_din_ready(core_din_ready),
    .core_dout(core_dout), .core_dout_valid(core_dout_valid),
    .core_dout_ready(core_dout_ready)
`ifdef GIMLI_HASH_XOF_EN
    , .xof_blocks(xof_blocks)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   oper;
    logic [4:0]   size;
    logic [127:0] din;
    bit           chk_din;
  } cmd_t;

  typedef struct {
    logic [127:0] dout;
    bit           last;
  } out_t;

  cmd_t exp_cmd[$];
  out_t exp_out[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   sq_seen = 0;
  bit   mute = 1'b0;
  bit   hold = 1'b0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Toy stand-in for the Gimli permutation; only bijective mixing matters here.
  function automatic logic [127:0] tperm(input logic [127:0] s);
    logic [63:0] a, b;
    a = s[63:0];
    b = s[127:64];
    for (int r = 0; r < 4; r++) begin
      a = a * 64'h9E3779B97F4A7C15 + {b[40:0], b[63:41]};
      b = b ^ {a[22:0], a[63:23]} ^ 64'(r + 1);
    end
    return {b, a};
  endfunction

  function automatic logic [127:0] padblk(input logic [127:0] d, input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) r[8*i +: 8] = d[8*i +: 8];
    end
    if (n < 16) r[8*n +: 8] = 8'h01;
    return r;
  endfunction

  // Stand-in round core: random permutation latency, one-deep output register.
  logic [127:0] cstate;
  logic [127:0] cdout;
  logic         cdout_v;
  int           lat;

  assign core_din_ready  = (lat == 0) && !cdout_v;
  assign core_dout       = cdout;
  assign core_dout_valid = cdout_v;

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cstate  <= '0;
      cdout   <= '0;
      cdout_v <= 1'b0;
      lat     <= 0;
    end else begin
      if (lat != 0) lat <= lat - 1;
      if (cdout_v && core_dout_ready) cdout_v <= 1'b0;
      if (core_din_valid && core_din_ready) begin
        lat <= int'($urandom_range(0, 3));
        case (core_oper)
          3'b111: cstate <= '0;
          3'b000: cstate <= tperm(cstate ^ padblk(core_din, int'(core_din_size)));
          3'b011: begin
            cdout   <= cstate;
            cdout_v <= 1'b1;
            cstate  <= tperm(cstate);
          end
          default: ;
        endcase
      end
    end
  end

  // Command monitor
  always @(negedge clk) begin
    cmd_t c;
    if (arstn && core_din_valid && core_din_ready) begin
      if (core_oper == 3'b011) sq_seen++;
      if (!mute) begin
        if (exp_cmd.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL cmd_unexpected: got oper %b with no command expected", core_oper);
        end else begin
          c = exp_cmd.pop_front();
          chk("cmd_oper", 128'(core_oper), 128'(c.oper));
          if (c.oper == 3'b000) chk("cmd_size", 128'(core_din_size), 128'(c.size));
          if (c.chk_din) chk("cmd_din", core_din, c.din);
        end
      end
    end
  end

  // Digest monitor
  always @(negedge clk) begin
    out_t o;
    if (arstn && hash_valid && hash_ready && !mute) begin
      if (exp_out.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out_unexpected: got word %h with no word expected", hash_dout);
      end else begin
        o = exp_out.pop_front();
        chk("hash_dout", hash_dout, o.dout);
        chk("hash_last", 128'(hash_last), 128'(o.last));
      end
    end
  end

  // Digest sink with random or forced backpressure
  initial begin
    hash_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      hash_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive_word(input logic [127:0] d, input logic [4:0] sz, input bit last);
    int t;
    t = 0;
    msg_din   = d;
    msg_size  = sz;
    msg_last  = last;
    msg_valid = 1'b1;
    @(negedge clk);
    while (!msg_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!msg_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL msg_accept_timeout: got msg_ready=0 after %0d cycles, required 1", t);
    end
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Builds a random message of len bytes, queues its expected commands and digest, then drives it.
  task automatic send_msg(input int len, input bit over, input int xof);
    byte unsigned b[$];
    logic [127:0] w[$];
    logic [127:0] wd, st, blk;
    int nw, eff, idx, n;
    logic [4:0] lsz;
    cmd_t c;
    out_t o;
`ifdef GIMLI_HASH_XOF_EN
    xof_blocks = 8'(xof);
    n = (xof == 0) ? 1 : xof;
`else
    n = 2 + 0 * xof;
`endif
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    nw  = (len == 0) ? 1 : (len + 15) / 16;
    eff = len - 16 * (nw - 1);
    for (int k = 0; k < nw; k++) begin
      wd = {$urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < 16; j++) begin
        if (16 * k + j < len) wd[8*j +: 8] = b[16*k + j];
      end
      w.push_back(wd);
    end
    lsz = 5'(eff);
    if (over && eff == 16) lsz = 5'($urandom_range(17, 31));

    c = '{oper: 3'b111, size: 5'd0, din: '0, chk_din: 1'b0};
    exp_cmd.push_back(c);
    for (int k = 0; k < nw; k++) begin
      c = '{oper: 3'b000, size: 5'((k < nw - 1) ? 16 : eff), din: w[k], chk_din: 1'b1};
      exp_cmd.push_back(c);
    end
    if (len > 0 && len % 16 == 0) begin
      c = '{oper: 3'b000, size: 5'd0, din: '0, chk_din: 1'b1};
      exp_cmd.push_back(c);
    end
    for (int q = 0; q < n; q++) begin
      c = '{oper: 3'b011, size: 5'd0, din: '0, chk_din: 1'b0};
      exp_cmd.push_back(c);
    end

    st  = '0;
    idx = 0;
    while (len - idx >= 16) begin
      blk = '0;
      for (int j = 0; j < 16; j++) blk[8*j +: 8] = b[idx + j];
      st = tperm(st ^ blk);
      idx += 16;
    end
    blk = '0;
    for (int j = 0; j < len - idx; j++) blk[8*j +: 8] = b[idx + j];
    st = tperm(st ^ padblk(blk, len - idx));
    for (int q = 0; q < n; q++) begin
      o = '{dout: st, last: (q == n - 1)};
      exp_out.push_back(o);
      st = tperm(st);
    end

    $display("msg len=%0d words=%0d last_size=%0d digest_words=%0d", len, nw, lsz, n);
    sq_seen = 0;
    for (int k = 0; k < nw; k++) begin
      drive_word(w[k], (k == nw - 1) ? lsz : 5'($urandom_range(0, 31)), (k == nw - 1));
`ifdef GIMLI_HASH_XOF_EN
      if (k == 0) xof_blocks = 8'($urandom);
`endif
    end
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_busy_done"}, 128'(busy), 128'(0));
    chk({nm, "_cmd_left"}, 128'(exp_cmd.size()), 128'(0));
    chk({nm, "_out_left"}, 128'(exp_out.size()), 128'(0));
  endtask

  initial begin
    int t;
    arstn     = 1'b1;
    msg_din   = '0;
    msg_size  = '0;
    msg_last  = 1'b0;
    msg_valid = 1'b0;
`ifdef GIMLI_HASH_XOF_EN
    xof_blocks = 8'd2;
`endif
    #1 arstn = 1'b0;
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_msg_ready", 128'(msg_ready), 128'(0));
    chk("rst_din_valid", 128'(core_din_valid), 128'(0));
    chk("rst_oper", 128'(core_oper), 128'(3'b111));
    chk("rst_din", core_din, 128'(0));
    chk("rst_size", 128'(core_din_size), 128'(0));
    chk("rst_hash_last", 128'(hash_last), 128'(0));
    chk("rst_hash_valid", 128'(hash_valid), 128'(0));
    repeat (3) @(posedge clk);
    #1 arstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send_msg(0, 1'b0, 2);
    wait_idle("empty");
    chk("empty_squeezes", 128'(sq_seen), 128'(2));
    send_msg(16, 1'b0, 2);
    wait_idle("len16");
    send_msg(20, 1'b0, 2);
    wait_idle("len20");
    send_msg(32, 1'b1, 2);
    wait_idle("len32_oversize");

    // Backpressure: the second squeeze must stall behind the unconsumed first word.
    hold = 1'b1;
    @(posedge clk);
    #1;
    send_msg(5, 1'b0, 2);
    t = 0;
    @(negedge clk);
    while (!hash_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (50) @(negedge clk);
    chk("bp_squeezes", 128'(sq_seen), 128'(1));
    chk("bp_busy", 128'(busy), 128'(1));
    chk("bp_hash_valid", 128'(hash_valid), 128'(1));
    hold = 1'b0;
    wait_idle("backpressure");

    // Abort mid-absorb
    mute = 1'b1;
    drive_word({$urandom, $urandom, $urandom, $urandom}, 5'd16, 1'b0);
    @(negedge clk);
    chk("abort_busy_pre", 128'(busy), 128'(1));
    #1 arstn = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_din_valid", 128'(core_din_valid), 128'(0));
    chk("abort_oper", 128'(core_oper), 128'(3'b111));
    chk("abort_sq_cnt", 128'(dut.sq_cnt_q), 128'(0));
    chk("abort_out_cnt", 128'(dut.out_cnt_q), 128'(0));
    @(posedge clk);
    #1 arstn = 1'b1;
    exp_cmd.delete();
    exp_out.delete();
    mute = 1'b0;
    @(posedge clk);
    #1;
    send_msg(0, 1'b0, 2);
    wait_idle("after_abort");

`ifdef GIMLI_HASH_XOF_EN
    send_msg(7, 1'b0, 4);
    wait_idle("xof4");
    chk("xof4_squeezes", 128'(sq_seen), 128'(4));
    send_msg(0, 1'b0, 0);
    wait_idle("xof0");
    chk("xof0_squeezes", 128'(sq_seen), 128'(1));
`endif

    for (int r = 0; r < 10; r++) begin
      int len;
      len = int'($urandom_range(0, 64));
      if ($urandom_range(0, 2) == 0) len = 16 * int'($urandom_range(0, 4));
      send_msg(len, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
      wait_idle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
